// File: rtl/mem_access_unit.sv
// Data-memory access unit: request/acknowledge bus master for loads and stores, with byte lanes and load extension.
// Optional build macro MAU_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse misalign with done.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        rw_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
`ifdef MAU_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state, state_nxt;
  size_t       req_size, op_size;
  logic        op_unsigned;
  logic [1:0]  off, op_off;
  logic        start, mis_now;
  logic [3:0]  be_nxt;
  logic [DATA_W-1:0] wdata_nxt, load_ext;

  assign start = (state == IDLE) && (memread || memwrite);
  assign off   = addr[1:0];

  // rw_type[1] set covers W plus the unlisted encodings 011/110/111, all treated as W.
  assign req_size = rw_type[1] ? SZ_W : (rw_type[0] ? SZ_H : SZ_B);

`ifdef MAU_MISALIGN_TRAP_EN
  logic mis_q;
  assign mis_now = ((req_size == SZ_H) && off[0]) || ((req_size == SZ_W) && (off != 2'b00));
`else
  assign mis_now = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    be_nxt    = 4'b1111;
    wdata_nxt = wdata;
    case (req_size)
      SZ_B: begin
        be_nxt    = 4'b0001 << off;
        wdata_nxt = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be_nxt    = off[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b   = bus_rdata[8*op_off +: 8];
    lane_h   = op_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_ext = bus_rdata;
    case (op_size)
      SZ_B:    load_ext = {{24{lane_b[7]  & ~op_unsigned}}, lane_b};
      SZ_H:    load_ext = {{16{lane_h[15] & ~op_unsigned}}, lane_h};
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = mis_now ? DONE : REQ;
      REQ:     if (bus_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; stall is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    bus_req = (state == REQ);
    done    = (state == DONE);
    stall   = rst_n && (start || (state == REQ));
  end

`ifdef MAU_MISALIGN_TRAP_EN
  assign misalign = done && mis_q;
`endif

  // Request capture and load-result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= 4'b0000;
      bus_wdata   <= '0;
      rdata       <= '0;
      op_size     <= SZ_W;
      op_unsigned <= 1'b0;
      op_off      <= 2'b00;
`ifdef MAU_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      if (start && !mis_now) begin
        bus_we      <= memwrite;
        bus_addr    <= {addr[ADDR_W-1:2], 2'b00};
        bus_be      <= be_nxt;
        bus_wdata   <= wdata_nxt;
        op_size     <= req_size;
        op_unsigned <= rw_type[2];
        op_off      <= off;
      end
`ifdef MAU_MISALIGN_TRAP_EN
      if (start) mis_q <= mis_now;
`endif
      if ((state == REQ) && bus_ack && !bus_we) rdata <= load_ext;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Responder side of the control decoder's memory-control interface.
- Consumes memread, memwrite and rw_type (funct3), together with the ALU-computed address and store data.
- Runs a request/acknowledge transaction on the data-memory bus, generating byte enables and store lane steering.
- Returns sign- or zero-extended load data and stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 32, width of the address input and bus address
- DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- memread  in  1  load requested by the instruction in the MEM stage
- memwrite  in  1  store requested
- rw_type  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from the ALU
- wdata  in  32  store data (rs2), low-aligned
- rdata  out  32  extended load result, valid while done=1
- stall  out  1  hold the pipeline
- done  out  1  one-cycle pulse when the access completes
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address, addr with bits [1:0] cleared
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-steered store data
- bus_ack  in  1  bus acknowledge; read data valid in the same cycle
- bus_rdata  in  32  raw word read data
- misalign  out  1  only present when MAU_MISALIGN_TRAP_EN is defined

Behaviour:
- Reset is asynchronous, active-low. On reset, every output is 0 and the state returns to IDLE.
- Reset asserted mid-transaction drops bus_req immediately; the access is abandoned and no done is produced.
- Start condition: start = (memread | memwrite) in IDLE.
  - If both memread and memwrite are 1, the access is a store.
- State machine, 3 states:
  - IDLE: on start, register bus_we, bus_addr, bus_be and bus_wdata, set bus_req=1, go to REQ. Otherwise stay.
  - REQ: hold bus_req and all bus outputs stable until bus_ack. On bus_ack: clear bus_req, register the extended rdata (loads only), go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. memread/memwrite are ignored in DONE, so the same instruction is never reissued.
- stall = (IDLE & start) | REQ. stall is combinational and low in DONE.
- Minimum latency is 3 cycles from start to done: ack in the first REQ cycle, then DONE in the following cycle.
- Wait states: each extra cycle without bus_ack adds one cycle.
- Byte enables, with off = addr[1:0]:
  - B: 0001 << off
  - H: 0011 << (off[1]*2)
  - W: 1111
  - Unlisted rw_type values (011, 110, 111) are treated as W.
- Store steering: bus_wdata is wdata[7:0] replicated ×4 for B, wdata[15:0] ×2 for H, and wdata for W.
- Load extraction: select the byte or halfword from bus_rdata by off.
  - B and H are sign-extended from bit 7 / bit 15.
  - BU and HU are zero-extended.
  - W passes through.
- rdata holds its value until the next load completes. Stores leave rdata unchanged.
- Without the trap option, misaligned H/W accesses are force-aligned: low offset bits are ignored as described above.

Optional Feature:
- Macro: MAU_MISALIGN_TRAP_EN.
- When defined:
  - An H access with addr[0]=1, or a W access with addr[1:0]!=0, issues no bus transaction.
  - IDLE goes directly to DONE; done=1 and misalign=1 pulse together for one cycle.
  - rdata and memory are unchanged.
- When undefined: the misalign port is absent and the force-align behaviour applies.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack 1 cycle after req → bus_be=1111, bus_wdata=0xDEADBEEF, bus_addr=0x100, done on cycle 3, stall high for 2 cycles.
- SB addr=0x103, wdata=0x000000A5 → bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1.
- LB addr=0x102, bus_rdata=0x12F03456 → rdata=0xFFFFFFF0. LBU at the same address → rdata=0x000000F0.
- LH addr=0x102, bus_rdata=0x80013456 → rdata=0xFFFF8001. LHU → rdata=0x00008001.
- LW with bus_ack delayed 4 cycles → bus outputs stable throughout REQ, stall high for 5 cycles, done single pulse. Drop rst_n during REQ → bus_req=0 at once, no done.
- With MAU_MISALIGN_TRAP_EN: LW addr=0x101 → no bus_req, done=misalign=1 on the next cycle. Without it: bus_addr=0x100, bus_be=1111.
